// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one ALU, req/ack memories.
// Define MULTICYCLE_DATAPATH_MULT_EN to enable R-type mul (funct 0x18).
module multicycle_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic                  IMemReq,
  output logic [DATA_WIDTH-1:0] IMemAddr,
  input  logic [31:0]           IMemRdata,
  input  logic                  IMemAck,
  output logic                  DMemReq,
  output logic                  DMemWe,
  output logic [DATA_WIDTH-1:0] DMemAddr,
  output logic [DATA_WIDTH-1:0] DMemWdata,
  input  logic [DATA_WIDTH-1:0] DMemRdata,
  input  logic                  DMemAck,
  output logic [DATA_WIDTH-1:0] WriteBackData,
  output logic                  WriteBackValid,
  output logic                  Trap
);

  localparam int RW = $clog2(REG_COUNT);
  localparam int SW = $clog2(DATA_WIDTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL, OP_MUL,
    OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_BAD
  } op_e;

  state_e state, nstate;
  logic   run;
  word_t  pc, a, b, alu_q, mdr, target, wbdata;
  logic [31:0] ir;
  logic   wbvalid;
  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] rf;

  logic [5:0] opc, fn;
  logic [4:0] rs, rt, rd;
  logic [SW-1:0] shamt;
  op_e    op;
  logic   bad_idx, illegal, take, ireq, dreq, wr;
  word_t  simm, alu, jaddr, wbval;
  logic [31:0] jfull;
  logic [RW-1:0] dst;

  assign opc   = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign fn    = ir[5:0];
  assign shamt = ir[6 +: SW];
  assign simm  = DATA_WIDTH'($signed(ir[15:0]));

  always_comb begin
    op = OP_BAD;
    case (opc)
      6'h00: begin
        case (fn)
          6'h20:   op = OP_ADD;
          6'h22:   op = OP_SUB;
          6'h24:   op = OP_AND;
          6'h25:   op = OP_OR;
          6'h2A:   op = OP_SLT;
          6'h00:   op = OP_SLL;
          6'h02:   op = OP_SRL;
`ifdef MULTICYCLE_DATAPATH_MULT_EN
          6'h18:   op = OP_MUL;
`endif
          default: op = OP_BAD;
        endcase
      end
      6'h08:   op = OP_ADDI;
      6'h23:   op = OP_LW;
      6'h2B:   op = OP_SW;
      6'h04:   op = OP_BEQ;
      6'h05:   op = OP_BNE;
      6'h02:   op = OP_J;
      default: op = OP_BAD;
    endcase
  end

  // j carries no register fields, so only the others are range-checked
  assign bad_idx = ({27'd0, rs} >= 32'(REG_COUNT))
                || ({27'd0, rt} >= 32'(REG_COUNT))
                || (opc == 6'h00 && {27'd0, rd} >= 32'(REG_COUNT));
  assign illegal = (op == OP_BAD) || (op != OP_J && bad_idx);

  always_comb begin
    alu = a + simm;
    unique case (1'b1)
      op == OP_ADD: alu = a + b;
      op == OP_SUB: alu = a - b;
      op == OP_AND: alu = a & b;
      op == OP_OR:  alu = a | b;
      op == OP_SLT: alu = word_t'($signed(a) < $signed(b));
      op == OP_SLL: alu = b << shamt;
      op == OP_SRL: alu = b >> shamt;
`ifdef MULTICYCLE_DATAPATH_MULT_EN
      op == OP_MUL: alu = a * b;
`endif
      default:      alu = a + simm;
    endcase
  end

  assign jfull = (32'(pc) & 32'hF000_0000) | {4'b0, ir[25:0], 2'b00};
  assign jaddr = jfull[DATA_WIDTH-1:0];
  assign take  = (op == OP_BEQ && a == b) || (op == OP_BNE && a != b);
  assign wbval = (op == OP_LW) ? mdr : alu_q;
  assign dst   = (opc == 6'h00) ? rd[RW-1:0] : rt[RW-1:0];

  // run holds requests off for the first cycle after reset release
  assign ireq = run && state == S_FETCH;
  assign dreq = state == S_MEM;
  assign wr   = dreq && op == OP_SW;

  assign IMemReq        = ireq;
  assign IMemAddr       = ireq ? pc : '0;
  assign DMemReq        = dreq;
  assign DMemWe         = wr;
  assign DMemAddr       = dreq ? alu_q : '0;
  assign DMemWdata      = wr ? b : '0;
  assign WriteBackData  = wbdata;
  assign WriteBackValid = wbvalid;
  assign Trap           = state == S_TRAP;

  always_comb begin
    nstate = state;
    unique case (state)
      S_FETCH:  if (ireq && IMemAck) nstate = S_DECODE;
      S_DECODE: nstate = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (op inside {OP_BEQ, OP_BNE, OP_J}) nstate = S_FETCH;
        else if (op inside {OP_LW, OP_SW})    nstate = S_MEM;
        else                                  nstate = S_WB;
      end
      S_MEM:    if (DMemAck) nstate = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     nstate = S_FETCH;
      S_TRAP:   nstate = S_TRAP;
      default:  nstate = S_FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= S_FETCH;
      run     <= 1'b0;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_q   <= '0;
      mdr     <= '0;
      target  <= '0;
      wbdata  <= '0;
      wbvalid <= 1'b0;
      rf      <= '0;
    end else begin
      state   <= nstate;
      run     <= 1'b1;
      wbvalid <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (ireq && IMemAck) begin
            ir <= IMemRdata;
            pc <= pc + word_t'(4);
          end
        end
        S_DECODE: begin
          a      <= rf[rs[RW-1:0]];
          b      <= rf[rt[RW-1:0]];
          target <= pc + (simm << 2);
        end
        S_EXEC: begin
          alu_q <= alu;
          if (take)            pc <= target;
          else if (op == OP_J) pc <= jaddr;
        end
        S_MEM: if (DMemAck && op == OP_LW) mdr <= DMemRdata;
        S_WB: begin
          if (dst != '0) begin
            rf[dst] <= wbval;
            wbdata  <= wbval;
            wbvalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle successor to the single-cycle Task 1 datapath: one FSM-sequenced core that fetches, decodes and executes a MIPS-encoded integer subset over a shared ALU, with external instruction and data memories behind req/ack handshakes so memory wait states stall the core. It sits between the testbench/top-level memories and replaces the combinational datapath-plus-controller pair. The write-back value is exported for observation.

## Interface
Parameters:
- DATA_WIDTH, 32, register/ALU/address width; 16..32.
- REG_COUNT, 32, architectural registers; 8, 16 or 32.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- IMemReq  out  1  instruction fetch request.
- IMemAddr  out  DATA_WIDTH  fetch byte address (PC).
- IMemRdata  in  32  instruction word, valid with IMemAck.
- IMemAck  in  1  fetch complete.
- DMemReq  out  1  data access request.
- DMemWe  out  1  1 = store, 0 = load.
- DMemAddr  out  DATA_WIDTH  rs + sign-extended imm.
- DMemWdata  out  DATA_WIDTH  rt value for stores.
- DMemRdata  in  DATA_WIDTH  load data, valid with DMemAck.
- DMemAck  in  1  data access complete.
- WriteBackData  out  DATA_WIDTH  last value written to the register file.
- WriteBackValid  out  1  one-cycle pulse per register write.
- Trap  out  1  sticky; illegal instruction seen.

## Operation
- Instructions: R-type (op 0) add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02; I-type addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05; j 0x02.
- Immediates sign-extended to DATA_WIDTH; shamt uses low log2(DATA_WIDTH) bits; arithmetic wraps modulo 2^DATA_WIDTH.
- Register 0 reads 0, writes discarded (no WriteBackValid pulse).
- Any rs/rt/rd index ≥ REG_COUNT, unknown opcode or funct → TRAP.
- States: FETCH → DECODE → EXEC → {MEM, WB, FETCH}; MEM → {WB, FETCH}; WB → FETCH; TRAP absorbing until Reset.
- FETCH: IMemReq=1, IMemAddr=PC; hold until IMemAck; on ack latch IR, PC←PC+4.
- DECODE: read rs/rt into A/B latches; compute branch target PC+(imm<<2).
- EXEC: ALU op. beq/bne: if taken PC←target; → FETCH. j: PC←{PC[top:28], IR[25:0],2'b00} truncated to DATA_WIDTH; → FETCH. lw/sw → MEM. others → WB.
- MEM: DMemReq=1 held until DMemAck; lw latches DMemRdata → WB; sw → FETCH.
- WB: write rd (R-type) or rt (addi/lw); WriteBackData updated, WriteBackValid=1 for that cycle.

## Timing
- Reset values: PC=RESET_PC, state FETCH, IMemReq=0, DMemReq=0, DMemWe=0, all address/data outputs 0, WriteBackData=0, WriteBackValid=0, Trap=0, registers 0.
- First IMemReq asserted the cycle after Reset deasserts.
- Ack sampled on the rising edge where req is high; zero-wait memory acks in the first request cycle.
- Zero-wait latency: branch/j 3 cycles, R-type/addi/sw 4, lw 5; each wait cycle adds one.
- Req and address/data remain stable while waiting; ack with req low is ignored.
- Reset during any state (incl. mid-handshake): req drops next cycle, no register write, returns to reset values.
- Branch to self legal; PC wraps at 2^DATA_WIDTH.

## Configuration
- MULTICYCLE_DATAPATH_MULT_EN defined: R-type funct 0x18 (mul) writes low DATA_WIDTH bits of signed rs×rt, same 4-cycle latency as add.
- Undefined: funct 0x18 → TRAP.

## Test plan
- Zero-wait memories, addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 → WriteBackData 5, 0xFFFFFFFD, 2; 12 cycles total.
- sw r3,8(r0) then lw r4,8(r0) with DMemAck delayed 3 cycles → DMemAddr 8, DMemWdata 2, r4=2, lw takes 8 cycles.
- beq r1,r1,-1 at PC 0x10 → IMemAddr repeats 0x10 every 3 cycles; bne r1,r1,+4 → next fetch 0x14.
- Opcode 0x3F or rd=20 with REG_COUNT=16 → Trap=1, no further IMemReq until Reset.
- Reset asserted while DMemReq high with no ack → DMemReq 0 next cycle, IMemAddr=RESET_PC after release.
- mul r5,r1,r2 (5×-3) → -15 with macro defined; Trap=1 without.
